// File: rtl/driver_inputs.sv
// Debounced switch/key read peripheral with sticky key-press and switch-change flags.
// Latency: read data and data_valid one cycle after a chip_select read; debounce takes 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; every selected bus cycle is accepted, one read response per cycle.
module driver_inputs #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chip_select,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        data_valid,
    input  logic [9:0]  sw,
    input  logic [3:0]  key
);
    localparam int NB = 14;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Bits [9:0] are switches, [13:10] are keys inverted so 1 = pressed.
    logic [NB-1:0]        raw_in;
    logic [NB-1:0]        sync_1;
    logic [NB-1:0]        sync_2;
    logic [NB-1:0]        deb;
    logic [NB-1:0]        upd;
    logic [CNT_WIDTH-1:0] cnt [NB];
    logic [3:0]           key_press;
    logic [9:0]           sw_change;
    logic                 bus_rd;
    logic                 bus_wr;
    logic [3:0]           key_clr;
    logic [9:0]           sw_clr;
    logic [31:0]          rd_mux;
    logic [21:0]          unused_wdata;

    assign raw_in       = {~key, sw};
    assign bus_rd       = chip_select & ~write_enable;
    assign bus_wr       = chip_select & write_enable;
    assign key_clr      = (bus_wr && addr == 2'd2) ? data_write[3:0] : 4'd0;
    assign sw_clr       = (bus_wr && addr == 2'd3) ? data_write[9:0] : 10'd0;
    assign unused_wdata = data_write[31:10];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // A bit commits only on the last cycle of an uninterrupted mismatch run.
    always_comb begin
        upd = '0;
        for (int i = 0; i < NB; i++) begin
            upd[i] = (sync_2[i] != deb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync_2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    deb[i] <= sync_2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Set terms are OR'ed after the clear so a coincident edge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_press <= '0;
            sw_change <= '0;
        end else begin
            key_press <= (key_press & ~key_clr) | (upd[13:10] & sync_2[13:10]);
            sw_change <= (sw_change & ~sw_clr) | upd[9:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd0:    rd_mux = {22'd0, deb[9:0]};
            2'd1:    rd_mux = {28'd0, deb[13:10]};
            2'd2:    rd_mux = {28'd0, key_press};
            default: rd_mux = {22'd0, sw_change};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_read  <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= bus_rd;
            if (bus_rd) begin
                data_read <= rd_mux;
            end
        end
    end
endmodule

// File: doc/driver_inputs.md
Name: driver_inputs

Overview:
- Memory-mapped read peripheral on the DLX data bus: exposes the board switches `sw[9:0]` and push-buttons `key[3:0]` to the processor.
- Debounces both input sets and keeps sticky edge/change flags that software clears by writing.
- Complements `driver_leds`, which handles the write direction.
- Decoded by the top level via `switches_cs`. Read data returns with the same 1-cycle registered latency as the data RAM (`rdata_valid` style).

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required before a debounced bit updates. Default is 10 ms at 50 MHz. Must be ≥ 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-bit debounce counter.

Ports:
- clk  in  1  system clock (clock_50)
- reset_n  in  1  asynchronous active-low reset
- chip_select  in  1  peripheral selected for the current bus cycle
- addr  in  2  register word select (d_address[3:2])
- write_enable  in  1  bus write strobe; qualified by chip_select
- data_write  in  32  write data (used for flag clear)
- data_read  out  32  registered read data
- data_valid  out  1  read data valid, 1-cycle pulse
- sw  in  10  raw slide switches, asynchronous
- key  in  4  raw push-buttons, asynchronous, active-low on pins

Behaviour:
- Reset (async, reset_n=0): data_read=0, data_valid=0, sync flops=0, debounced sw=0, debounced key (pressed, active-high)=0, all counters=0, all flags=0.
- Synchronisers:
  - Each raw bit passes through 2 flops.
  - key is inverted before the synchroniser, so 1 = pressed internally.
- Debounce, per bit, independent of other bits:
  - If synced == debounced: cnt<=0.
  - Else if cnt == DEBOUNCE_CYCLES-1: debounced<=synced, cnt<=0.
  - Else: cnt<=cnt+1.
  - Timing: pin stable from before edge k → debounced updates at edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles resets the counter and never updates the debounced value.
- Register map (word offsets; unmapped bits read 0):
  - 0: SW_STATE, [9:0] debounced sw. Read-only.
  - 1: KEY_STATE, [3:0] debounced key, 1 = pressed. Read-only.
  - 2: KEY_PRESS, [3:0] sticky, set on a debounced 0→1 key transition. Write-1-to-clear.
  - 3: SW_CHANGE, [9:0] sticky, set on any debounced sw transition. Write-1-to-clear. Also sets on the first post-reset update if a switch is already 1.
- Flags are set at the same edge the debounced bit updates.
- Read:
  - Trigger: chip_select=1 and write_enable=0 sampled at edge j.
  - After edge j: data_read = selected register value as of before edge j; data_valid=1.
  - After edge j+1: data_valid=0 unless another read was sampled.
  - data_read holds its last value when not reading.
  - Back-to-back reads give one valid per cycle.
- Write:
  - Trigger: chip_select=1 and write_enable=1.
  - Offset 2: KEY_PRESS &= ~data_write[3:0].
  - Offset 3: SW_CHANGE &= ~data_write[9:0].
  - Offsets 0/1: ignored.
  - data_valid stays 0 on writes.
- Simultaneous set and clear on the same bit in the same cycle: set wins (the flag stays 1).
- chip_select=0: no register changes from the bus; debounce logic and flags keep running.
- Reset mid-debounce: counter and debounced value return to 0. Re-qualification starts from scratch after release.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, sw=0, key=4'hF: read offsets 0..3 → data_read=0 each, data_valid high exactly 1 cycle after each request.
- sw=10'h2A5 stable from edge 10 → SW_STATE reads 0 before edge 15 and 0x2A5 from edge 15; SW_CHANGE=0x2A5.
- key[1] pulled low for 3 synced cycles then released → KEY_STATE and KEY_PRESS remain 0. Held low ≥5 cycles → KEY_STATE=0x2, KEY_PRESS=0x2. Release → KEY_STATE=0, KEY_PRESS still 0x2.
- Write 0x2 to offset 2 → KEY_PRESS=0. Write 0xFFFF_FFFF to offset 0 → SW_STATE unchanged, data_valid stays 0.
- key[0] debounced press lands in the same cycle as a write of 0x1 to offset 2 → KEY_PRESS[0]=1 (set wins).
- reset_n asserted mid-debounce (counter=2), then released with inputs held → all registers 0 immediately; values reappear 1+DEBOUNCE_CYCLES edges after the first post-reset edge.
